// File: rtl/decode_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_pkg: shared pipeline types for the decode/execute boundary. Rev 1.0
// ----------------------------------------------------------------------------
package decode_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_SHAMT = 3'd4,
    IMM_U     = 3'd5
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_t;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic        register_write;
    result_src_t result_src;
    logic        mem_load;
    logic        mem_store;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  branch_op;
    logic [3:0]  alu_control;
    logic        alu_src;
  } id_exe_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_decoder: opcode/funct to execute-stage control and imm format. Rev 1.0
// ----------------------------------------------------------------------------
module control_decoder
  import decode_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  output id_exe_ctrl_t ctrl,
  output imm_src_t     imm_src
);

  always_comb begin
    ctrl             = '0;
    imm_src          = IMM_I;
    ctrl.branch_op   = funct3;
    ctrl.alu_control = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        ctrl.register_write = 1'b1;
        ctrl.alu_control    = {funct7_5, funct3};
      end
      OPC_OP_IMM: begin
        ctrl.register_write = 1'b1;
        ctrl.alu_src        = 1'b1;
        // Only shifts carry funct7; other immediates would leak imm bit 10.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_src          = IMM_SHAMT;
          ctrl.alu_control = {funct7_5 & (funct3 == 3'b101), funct3};
        end else begin
          ctrl.alu_control = {1'b0, funct3};
        end
      end
      OPC_LOAD: begin
        ctrl.register_write = 1'b1;
        ctrl.mem_load       = 1'b1;
        ctrl.result_src     = RES_MEM;
        ctrl.alu_src        = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_store = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm_src          = IMM_B;
      end
      OPC_JAL: begin
        ctrl.register_write = 1'b1;
        ctrl.jal            = 1'b1;
        ctrl.result_src     = RES_PC4;
        imm_src             = IMM_J;
      end
      OPC_JALR: begin
        ctrl.register_write = 1'b1;
        ctrl.jalr           = 1'b1;
        ctrl.result_src     = RES_PC4;
        ctrl.alu_src        = 1'b1;
      end
      OPC_LUI: begin
        ctrl.register_write = 1'b1;
        ctrl.alu_src        = 1'b1;
        ctrl.alu_control    = ALU_PASS_B;
        imm_src             = IMM_U;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_reg_file_2r1w.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_file_2r1w: scalar register file, x0 hardwired, write-back bypass. Rev 1.0
// ----------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter logic [XLEN-1:0] SP_INIT = 'h300,
  parameter logic [XLEN-1:0] GP_INIT = 'h300
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int RW = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];

  function automatic logic in_range(input logic [4:0] a);
    return 32'(a) < NREGS;
  endfunction

  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      a,
    input logic            we,
    input logic [4:0]      wa,
    input logic [XLEN-1:0] wd,
    input logic [XLEN-1:0] stored
  );
    if (a == 5'd0)            return '0;
    if (we && wa == a)        return wd;
    if (in_range(a))          return stored;
    return '0;
  endfunction

  assign rd1 = read_port(ra1, wr_en, wr_addr, wr_data, r_regs[ra1[RW-1:0]]);
  assign rd2 = read_port(ra2, wr_en, wr_addr, wr_data, r_regs[ra2[RW-1:0]]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= (i == 2) ? SP_INIT : (i == 3) ? GP_INIT : '0;
    end else if (wr_en && wr_addr != 5'd0 && in_range(wr_addr)) begin
      r_regs[wr_addr[RW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage: RV32I/RV32E decode with load-use stall and flush. Rev 1.0
// ----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter logic [XLEN-1:0] SP_INIT = 'h300,
  parameter logic [XLEN-1:0] GP_INIT = 'h300
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_inc,
  output logic            out_valid,
  input  logic            out_ready,
  output id_exe_ctrl_t    out_ctrl,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [4:0]      out_a1,
  output logic [4:0]      out_a2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_inc,
  output logic            out_illegal,
  input  logic            wb_wr_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wr_data
);

  logic [4:0]        w_a1, w_a2, w_rd;
  id_exe_ctrl_t      w_ctrl, w_ctrl_safe;
  imm_src_t          w_imm_src;
  logic [XLEN-1:0]   w_imm, w_rs1, w_rs2;
  logic              w_illegal, w_hazard, w_load, w_take;
  logic signed [11:0] w_imm_i, w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [20:0] w_imm_j;
  logic signed [31:0] w_imm_u;

  assign w_a1 = in_instr[19:15];
  assign w_a2 = in_instr[24:20];
  assign w_rd = in_instr[11:7];

  control_decoder u_ctrl (
    .opcode   (in_instr[6:0]),
    .funct3   (in_instr[14:12]),
    .funct7_5 (in_instr[30]),
    .ctrl     (w_ctrl),
    .imm_src  (w_imm_src)
  );

  reg_file_2r1w #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .SP_INIT (SP_INIT),
    .GP_INIT (GP_INIT)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra1     (w_a1),
    .ra2     (w_a2),
    .rd1     (w_rs1),
    .rd2     (w_rs2),
    .wr_en   (wb_wr_en),
    .wr_addr (wb_rd),
    .wr_data (wb_wr_data)
  );

  assign w_imm_i = in_instr[31:20];
  assign w_imm_s = {in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};

  always_comb begin
    w_imm = '0;
    case (w_imm_src)
      IMM_I:     w_imm = XLEN'(w_imm_i);
      IMM_S:     w_imm = XLEN'(w_imm_s);
      IMM_B:     w_imm = XLEN'(w_imm_b);
      IMM_J:     w_imm = XLEN'(w_imm_j);
      IMM_SHAMT: w_imm = XLEN'(in_instr[24:20]);
      IMM_U:     w_imm = XLEN'(w_imm_u);
      default:   w_imm = '0;
    endcase
  end

  // Out-of-range registers only exist in the RV32E configuration.
  assign w_illegal = (32'(w_a1) >= NREGS) | (32'(w_a2) >= NREGS) | (32'(w_rd) >= NREGS);

  always_comb begin
    w_ctrl_safe = w_ctrl;
    if (w_illegal) begin
      w_ctrl_safe.register_write = 1'b0;
      w_ctrl_safe.mem_load       = 1'b0;
      w_ctrl_safe.mem_store      = 1'b0;
    end
  end

  assign w_hazard = out_valid && out_ctrl.mem_load && (out_rd != 5'd0) &&
                    ((out_rd == w_a1) || (out_rd == w_a2)) && in_valid;
  assign in_ready = flush | ((!out_valid | out_ready) & !w_hazard);
  assign w_load   = !out_valid | out_ready | flush;
  assign w_take   = in_valid & in_ready & !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_a1      <= '0;
      out_a2      <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_pc_inc  <= '0;
      out_illegal <= 1'b0;
    end else if (w_load) begin
      out_valid <= w_take;
      if (w_take) begin
        out_ctrl    <= w_ctrl_safe;
        out_rs1     <= w_rs1;
        out_rs2     <= w_rs2;
        out_a1      <= w_a1;
        out_a2      <= w_a2;
        out_rd      <= w_rd;
        out_imm     <= w_imm;
        out_pc      <= in_pc;
        out_pc_inc  <= in_pc_inc;
        out_illegal <= w_illegal;
      end else begin
        out_ctrl <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decode_stage: directed and random checks of decode_stage. Rev 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage;
  import decode_pkg::*;

  localparam int K_ADD = 0, K_ADDI = 1, K_SLLI = 2, K_LW = 3,
                 K_SW = 4, K_BEQ = 5, K_LUI = 6, K_JAL = 7;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, wb_wr_en;
  logic [31:0] in_instr, in_pc, in_pc_inc, wb_wr_data;
  logic [4:0]  wb_rd;

  logic in_ready, out_valid, out_illegal;
  id_exe_ctrl_t out_ctrl;
  logic [31:0] out_rs1, out_rs2, out_imm, out_pc, out_pc_inc;
  logic [4:0]  out_a1, out_a2, out_rd;

  logic in_ready_16, out_valid_16, out_illegal_16;
  id_exe_ctrl_t out_ctrl_16;
  logic [31:0] out_rs1_16, out_rs2_16, out_imm_16, out_pc_16, out_pc_inc_16;
  logic [4:0]  out_a1_16, out_a2_16, out_rd_16;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc_inc(in_pc_inc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_a1(out_a1), .out_a2(out_a2),
    .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc), .out_pc_inc(out_pc_inc),
    .out_illegal(out_illegal), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_wr_data(wb_wr_data)
  );

  decode_stage #(.NREGS(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_16),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc_inc(in_pc_inc),
    .out_valid(out_valid_16), .out_ready(out_ready), .out_ctrl(out_ctrl_16),
    .out_rs1(out_rs1_16), .out_rs2(out_rs2_16), .out_a1(out_a1_16), .out_a2(out_a2_16),
    .out_rd(out_rd_16), .out_imm(out_imm_16), .out_pc(out_pc_16), .out_pc_inc(out_pc_inc_16),
    .out_illegal(out_illegal_16), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_wr_data(wb_wr_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference: architectural registers plus the expected execute-bound bundle.
  logic [31:0] mregs [32];
  int          cur_kind;
  logic [31:0] cur_imm;
  logic        rdy_seen;
  logic        m_valid, m_rw, m_load, m_store, m_branch, m_jal, m_alu_src, m_chk_imm;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [31:0] m_rs1, m_rs2, m_imm, m_pc, m_pc_inc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    case (k)
      K_ADD:   return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_ADDI:  return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      K_SLLI:  return {7'b0, imm[4:0], rs1, 3'b001, rd, 7'b0010011};
      K_LW:    return {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      K_SW:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      K_BEQ:   return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      K_LUI:   return {imm[31:12], rd, 7'b0110111};
      default: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endcase
  endfunction

  task automatic set_ins(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    cur_kind = k;
    cur_imm  = imm;
    in_instr = enc(k, rd, rs1, rs2, imm);
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic cycle(input bit r, input bit f, input bit v, input bit o,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
    logic [4:0] a1, a2, rd;
    logic haz, rdy;
    rst = r; flush = f; in_valid = v; out_ready = o;
    wb_wr_en = we; wb_rd = wa; wb_wr_data = wd;
    in_pc = $urandom & 32'hFFFF_FFFC;
    in_pc_inc = in_pc + 4;
    a1 = in_instr[19:15]; a2 = in_instr[24:20]; rd = in_instr[11:7];
    haz = m_valid && m_load && m_rd != 0 && (m_rd == a1 || m_rd == a2) && v;
    rdy = f || ((!m_valid || o) && !haz);
    #1;
    rdy_seen = in_ready;
    if (!r) chk("in_ready", in_ready, rdy);
    if (r) begin
      m_valid = 0; m_rw = 0; m_load = 0; m_store = 0; m_branch = 0; m_jal = 0; m_alu_src = 0;
      for (int i = 0; i < 32; i++) mregs[i] = (i == 2 || i == 3) ? 32'h300 : 32'h0;
    end else begin
      if (!m_valid || o || f) begin
        if (v && rdy && !f) begin
          m_valid = 1; m_a1 = a1; m_a2 = a2; m_rd = rd;
          m_rs1 = rd_model(a1, we, wa, wd);
          m_rs2 = rd_model(a2, we, wa, wd);
          m_imm = cur_imm; m_chk_imm = (cur_kind != K_ADD);
          m_pc = in_pc; m_pc_inc = in_pc_inc;
          m_rw = !(cur_kind == K_SW || cur_kind == K_BEQ);
          m_load = (cur_kind == K_LW); m_store = (cur_kind == K_SW);
          m_branch = (cur_kind == K_BEQ); m_jal = (cur_kind == K_JAL);
          m_alu_src = (cur_kind inside {K_ADDI, K_SLLI, K_LW, K_SW, K_LUI});
        end else begin
          m_valid = 0; m_rw = 0; m_load = 0; m_store = 0; m_branch = 0; m_jal = 0; m_alu_src = 0;
        end
      end
      if (we && wa != 0) mregs[wa] = wd;
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_valid);
    if (r) begin
      chk("rst_rs1", out_rs1, 0); chk("rst_rs2", out_rs2, 0); chk("rst_imm", out_imm, 0);
      chk("rst_pc", out_pc, 0); chk("rst_pc_inc", out_pc_inc, 0);
      chk("rst_idx", {out_a1, out_a2, out_rd}, 0); chk("rst_illegal", out_illegal, 0);
    end
    if (m_valid) begin
      chk("rs1", out_rs1, m_rs1); chk("rs2", out_rs2, m_rs2);
      chk("a1", out_a1, m_a1); chk("a2", out_a2, m_a2); chk("rd", out_rd, m_rd);
      if (m_chk_imm) chk("imm", out_imm, m_imm);
      chk("pc", out_pc, m_pc); chk("pc_inc", out_pc_inc, m_pc_inc);
      chk("illegal", out_illegal, 0);
      chk("reg_write", out_ctrl.register_write, m_rw);
      chk("mem_load", out_ctrl.mem_load, m_load);
      chk("mem_store", out_ctrl.mem_store, m_store);
      chk("branch", out_ctrl.branch, m_branch);
      chk("jal", out_ctrl.jal, m_jal);
      chk("alu_src", out_ctrl.alu_src, m_alu_src);
    end else begin
      chk("bubble_ctrl", 32'(out_ctrl), 0);
    end
  endtask

  function automatic logic [31:0] rand_imm(input int k);
    logic [31:0] v;
    v = $urandom;
    case (k)
      K_ADDI, K_LW, K_SW: return {{20{v[11]}}, v[11:0]};
      K_SLLI:             return {27'b0, v[4:0]};
      K_BEQ:              return {{19{v[12]}}, v[12:1], 1'b0};
      K_LUI:              return {v[31:12], 12'b0};
      K_JAL:              return {{11{v[20]}}, v[20:1], 1'b0};
      default:            return 0;
    endcase
  endfunction

  initial begin
    int k;
    m_valid = 0; m_load = 0; m_rd = 0; m_chk_imm = 0;
    set_ins(K_ADDI, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);

    // RV32E instance flags x17 and suppresses the write.
    set_ins(K_ADD, 17, 1, 2, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("illegal16", out_illegal_16, 1);
    chk("rw16", out_ctrl_16.register_write, 0);
    chk("ready_after_rst", rdy_seen, 1);

    set_ins(K_ADDI, 1, 2, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("sp_init", out_rs1, 32'h300);

    set_ins(K_ADDI, 5, 0, 0, 7);
    cycle(0, 0, 1, 1, 0, 0, 0);
    set_ins(K_ADD, 6, 5, 5, 0);
    cycle(0, 0, 1, 1, 1, 5, 7);
    chk("bypass_rs1", out_rs1, 7);
    chk("bypass_rs2", out_rs2, 7);

    set_ins(K_LW, 7, 2, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    set_ins(K_ADD, 8, 7, 1, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("lu_stall_ready", rdy_seen, 0);
    chk("lu_bubble_ctrl", 32'(out_ctrl), 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("lu_issue_rd", out_rd, 8);

    set_ins(K_LW, 7, 2, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    set_ins(K_ADD, 8, 9, 1, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("nodep_ready", rdy_seen, 1);
    set_ins(K_LW, 0, 2, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    set_ins(K_ADD, 8, 0, 1, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("rd0_ready", rdy_seen, 1);

    set_ins(K_ADDI, 10, 1, 0, 123);
    cycle(0, 0, 1, 1, 0, 0, 0);
    set_ins(K_ADDI, 11, 1, 0, 55);
    repeat (3) begin
      cycle(0, 0, 1, 0, 0, 0, 0);
      chk("bp_ready", rdy_seen, 0);
      chk("bp_hold_rd", out_rd, 10);
    end
    cycle(0, 1, 1, 0, 0, 0, 0);
    chk("flush_valid", out_valid, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("flush_discard", out_valid, 0);

    cycle(0, 0, 0, 1, 1, 0, 5);
    set_ins(K_ADDI, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("x0_read", out_rs1, 0);

    set_ins(K_BEQ, 0, 1, 2, 32'hFFFF_FFFC);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("imm_b", out_imm, 32'hFFFF_FFFC);
    set_ins(K_LUI, 1, 0, 0, 32'hABCD_E000);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("imm_u", out_imm, 32'hABCD_E000);
    set_ins(K_SLLI, 1, 1, 0, 31);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("imm_shamt", out_imm, 31);

    set_ins(K_ADDI, 12, 0, 0, 9);
    cycle(0, 0, 1, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 1, 5, 32'hDEAD);
    chk("rst_drop_valid", out_valid, 0);
    set_ins(K_ADDI, 1, 5, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("rst_wb_dropped", out_rs1, 0);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 7);
      set_ins(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), rand_imm(k));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
